shift_add_mult: RTL
===================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width 8 bits.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request to multiply A by B; sampled on rising edge.
REQ-005 A  input  4  multiplicand, unsigned.
REQ-006 B  input  4  multiplier, unsigned.
REQ-007 BUSY  output  1  high while a multiplication is in progress.
REQ-008 DONE  output  1  one-cycle pulse: P holds a new result.
REQ-009 P  output  8  product A*B, unsigned; registered.

Function
REQ-010 Block SHALL instantiate one ripple_adder (4-bit A/B in, 5-bit X out) as its only adder; no behavioural "+" on datapath operands.
REQ-011 Internal registers SHALL be: M[3:0] latched multiplicand, ACC[3:0] partial high half, Q[3:0] multiplier/partial low half, CNT[2:0] step counter, state.
REQ-012 States SHALL be IDLE, CALC, DONE; encoding free.
REQ-013 IDLE: START=1 SHALL latch M<=A, Q<=B, ACC<=0, CNT<=0, move to CALC; START=0 stays IDLE.
REQ-014 START SHALL be ignored in CALC and DONE; A/B changes after acceptance SHALL not affect the result.
REQ-015 CALC, each cycle: adder inputs are ACC and (Q[0] ? M : 4'h0); with 5-bit sum X, SHALL update {ACC,Q} <= {X,Q} >> 1 (i.e. ACC<=X[4:1], Q<={X[0],Q[3:1]}), CNT<=CNT+1.
REQ-016 CALC SHALL last exactly 4 cycles; on the 4th step (CNT==3) SHALL load P <= {X,Q}>>1 low 8 bits and move to DONE.
REQ-017 DONE SHALL last exactly one cycle, then IDLE.
REQ-018 Timing: START high in cycle 0 (IDLE) -> BUSY high cycles 1-4, DONE high cycle 5, P valid from cycle 5; earliest next accepted START in cycle 6.
REQ-019 BUSY SHALL be high iff state==CALC; DONE high iff state==DONE; both combinational decodes of state register.
REQ-020 P SHALL change only on the transition CALC->DONE and on reset; it holds the previous result throughout a new calculation.
REQ-021 Result SHALL be exact for all 256 operand pairs; max 15*15=225 (8'hE1), no overflow possible.
REQ-022 Operand 0 on either side SHALL still take the full 4 CALC cycles (no early termination).

Reset
REQ-023 RST=1 at a rising edge SHALL force state=IDLE, M=ACC=Q=0, CNT=0, P=8'h00; BUSY=0, DONE=0 from the following cycle.
REQ-024 RST SHALL take priority over START and over any CALC step, including mid-calculation; the aborted operation SHALL produce no DONE and leave P=0.
REQ-025 First START after RST deasserts SHALL be accepted normally (no extra idle cycle required).

Verification
REQ-026 A=3, B=5, START 1 cycle -> BUSY cycles 1-4, DONE pulse cycle 5, P=8'h0F.
REQ-027 A=15, B=15 -> P=8'hE1 at DONE; A=0, B=9 -> P=8'h00 with identical 5-cycle latency.
REQ-028 Start A=7,B=6; in cycle 2 assert START with A=2,B=2 -> ignored, single DONE, P=8'h2A; P shows previous value until cycle 5.
REQ-029 Start A=9,B=9; assert RST in cycle 3 -> BUSY=0, P=8'h00, no DONE pulse; then A=4,B=4 START -> P=8'h10 five cycles later.
REQ-030 Exhaustive sweep A,B in 0..15, START each time BUSY=0 and DONE=0 -> P==A*B at every DONE, 256 DONE pulses, bench stops with error message on first mismatch.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned shift-add multiplier.
// A single 4-bit ripple-carry adder is reused over four CALC cycles. Each cycle
// it adds the multiplicand (or zero) to the high half, then shifts {ACC,Q} right by one.

// Plain 4-bit ripple-carry adder with a 5-bit sum (carry-out in bit 4).
module ripple_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [4:0] X
);

    logic [4:0] carry;

    // Carry chain rippling from bit 0 upward
    always_comb begin
        carry = '0;
        X     = '0;
        for (int i = 0; i < 4; i++) begin
            X[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        X[4] = carry[4];
    end

endmodule

module shift_add_mult (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] P
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] m;      // latched multiplicand
    logic [3:0] acc;    // partial product, high half
    logic [3:0] q;      // multiplier bits still to consume / low half of product
    logic [2:0] cnt;    // CALC step, 0..3

    logic [3:0] addend;
    logic [4:0] sum;

    // Only add the multiplicand when the current multiplier bit is set
    assign addend = q[0] ? m : 4'h0;

    ripple_adder u_adder (
        .A (acc),
        .B (addend),
        .X (sum)
    );

    // Status flags decode the state register directly
    assign BUSY = (state == S_CALC);
    assign DONE = (state == S_DONE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: START only matters in IDLE; CALC always runs four steps
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (START) next_state = S_CALC;
            S_CALC:  if (cnt == 3'd3) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Operand capture, shift-add step, and result load on the final step
    always_ff @(posedge CLK) begin
        if (RST) begin
            m   <= 4'h0;
            acc <= 4'h0;
            q   <= 4'h0;
            cnt <= 3'd0;
            P   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        m   <= A;
                        q   <= B;
                        acc <= 4'h0;
                        cnt <= 3'd0;
                    end
                end
                S_CALC: begin
                    acc <= sum[4:1];
                    q   <= {sum[0], q[3:1]};
                    cnt <= cnt + 3'd1;
                    // Final step: the shifted {sum, q} is the full product
                    if (cnt == 3'd3) begin
                        P <= {sum, q[3:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
